// File: rtl/ts_pkg.sv
// Shared helpers for the timescale timebase: counter-width function and the
// timestamp snapshot type handed to consumers.
package ts_pkg;

    localparam int TS_UNIT_W_MAX = 64;
    localparam int TS_FRAC_W_MAX = 32;

    // Width of a modulo-n counter; a modulo-1 counter still needs one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [TS_UNIT_W_MAX-1:0] units;
        logic [TS_FRAC_W_MAX-1:0] frac;
    } ts_t;

endpackage

// File: rtl/ts_prescaler.sv
// Generic modulo-N counter: counts 0..N-1 on enabled edges and emits a
// registered one-cycle tc pulse in the cycle after the terminal count.
module ts_prescaler
    import ts_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  en,
    output logic [cnt_w(N)-1:0]   count,
    output logic                  tc
);

    localparam int CNT_W = cnt_w(N);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             last;

    assign last = en && (cnt_q == CNT_W'(N - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (last) begin
            cnt_d = '0;
            tc_d  = 1'b1;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign count = cnt_q;
    assign tc    = tc_q;

endmodule

// File: rtl/ts_module_core.sv
// Timescale timebase: clock -> precision ticks -> unit ticks with a free-running
// units/frac timestamp. Define TS_ALARM_EN to add the one-shot unit alarm.
module ts_module_core
    import ts_pkg::*;
#(
    parameter int CLK_PER_TICK   = 4,
    parameter int TICKS_PER_UNIT = 1000,
    parameter int UNIT_W         = 32
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic                              clear,
`ifdef TS_ALARM_EN
    input  logic [UNIT_W-1:0]                 alarm_units,
    input  logic                              alarm_arm,
    output logic                              alarm,
`endif
    output logic                              prec_tick,
    output logic                              unit_tick,
    output logic [UNIT_W-1:0]                 ts_units,
    output logic [cnt_w(TICKS_PER_UNIT)-1:0]  ts_frac,
    output logic                              wrap
);

    localparam int PCNT_W = cnt_w(CLK_PER_TICK);
    localparam int FRAC_W = cnt_w(TICKS_PER_UNIT);

    logic [PCNT_W-1:0] pcnt;
    logic              prec_adv;
    logic              unit_adv;
    logic [UNIT_W-1:0] units_q, units_d;
    logic              wrap_q, wrap_d;

    // Advance strobes are the edges on which the registered tick pulses rise, so
    // frac and units move on exactly the edge their tick becomes visible.
    assign prec_adv = enable && !clear && (pcnt == PCNT_W'(CLK_PER_TICK - 1));
    assign unit_adv = prec_adv && (ts_frac == FRAC_W'(TICKS_PER_UNIT - 1));

    ts_prescaler #(.N(CLK_PER_TICK)) u_prec (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .en      (enable),
        .count   (pcnt),
        .tc      (prec_tick)
    );

    ts_prescaler #(.N(TICKS_PER_UNIT)) u_unit (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .en      (prec_adv),
        .count   (ts_frac),
        .tc      (unit_tick)
    );

    always_comb begin
        units_d = units_q;
        wrap_d  = 1'b0;
        if (clear) begin
            units_d = '0;
        end else if (unit_adv) begin
            units_d = units_q + UNIT_W'(1);
            wrap_d  = (units_q == '1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            units_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            units_q <= units_d;
            wrap_q  <= wrap_d;
        end
    end

    assign ts_units = units_q;
    assign wrap     = wrap_q;

`ifdef TS_ALARM_EN
    logic              armed_q, armed_d;
    logic              alarm_q, alarm_d;
    logic [UNIT_W-1:0] cmp_q, cmp_d;

    // A fresh arm request takes precedence over a match in the same cycle.
    always_comb begin
        armed_d = armed_q;
        cmp_d   = cmp_q;
        alarm_d = 1'b0;
        if (clear) begin
            armed_d = 1'b0;
        end else if (alarm_arm) begin
            armed_d = 1'b1;
            cmp_d   = alarm_units;
        end else if (armed_q && unit_adv && (units_d == cmp_q)) begin
            alarm_d = 1'b1;
            armed_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed_q <= 1'b0;
            alarm_q <= 1'b0;
            cmp_q   <= '0;
        end else begin
            armed_q <= armed_d;
            alarm_q <= alarm_d;
            cmp_q   <= cmp_d;
        end
    end

    assign alarm = alarm_q;
`endif

endmodule

// File: tb/tb_ts_module_core.sv
// Self-checking bench for ts_module_core (CLK_PER_TICK=4, TICKS_PER_UNIT=10, UNIT_W=4);
// a behavioural timebase model pushes expected outputs that are popped after each edge.
module tb_ts_module_core;

    localparam int CPT = 4;
    localparam int TPU = 10;
    localparam int UW  = 4;
    localparam int UMAX = (1 << UW) - 1;

    logic          clock   = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable  = 1'b0;
    logic          clear   = 1'b0;
    logic          prec_tick;
    logic          unit_tick;
    logic          wrap;
    logic [UW-1:0] ts_units;
    logic [3:0]    ts_frac;
`ifdef TS_ALARM_EN
    logic [UW-1:0] alarm_units = '0;
    logic          alarm_arm   = 1'b0;
    logic          alarm;
`endif

    typedef struct packed {
        logic          prec;
        logic          unit;
        logic          wrp;
        logic          alm;
        logic [UW-1:0] units;
        logic [3:0]    frac;
    } obs_t;

    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    int   m_pcnt  = 0;
    int   m_frac  = 0;
    int   m_units = 0;
    int   m_cmp   = 0;
    bit   m_armed = 1'b0;

    ts_module_core #(
        .CLK_PER_TICK   (CPT),
        .TICKS_PER_UNIT (TPU),
        .UNIT_W         (UW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .clear       (clear),
`ifdef TS_ALARM_EN
        .alarm_units (alarm_units),
        .alarm_arm   (alarm_arm),
        .alarm       (alarm),
`endif
        .prec_tick   (prec_tick),
        .unit_tick   (unit_tick),
        .ts_units    (ts_units),
        .ts_frac     (ts_frac),
        .wrap        (wrap)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic obs_t observe();
        obs_t o;
        o.prec  = prec_tick;
        o.unit  = unit_tick;
        o.wrp   = wrap;
`ifdef TS_ALARM_EN
        o.alm   = alarm;
`else
        o.alm   = 1'b0;
`endif
        o.units = ts_units;
        o.frac  = ts_frac;
        return o;
    endfunction

    function automatic void model_reset();
        m_pcnt  = 0;
        m_frac  = 0;
        m_units = 0;
        m_armed = 1'b0;
        sb.delete();
    endfunction

    // Drive one edge's inputs, push the model's expectation, and return #1 after the edge.
    task automatic drive(input logic en, input logic clr, input logic arm, input logic [UW-1:0] aunits);
        obs_t e;
        @(negedge clock);
        enable = en;
        clear  = clr;
`ifdef TS_ALARM_EN
        alarm_arm   = arm;
        alarm_units = aunits;
`endif
        e = '0;
        if (clr) begin
            m_pcnt  = 0;
            m_frac  = 0;
            m_units = 0;
            m_armed = 1'b0;
        end else begin
            if (en) begin
                if (m_pcnt == CPT - 1) begin
                    m_pcnt = 0;
                    e.prec = 1'b1;
                    if (m_frac == TPU - 1) begin
                        m_frac = 0;
                        e.unit = 1'b1;
                        if (m_units == UMAX) begin
                            m_units = 0;
                            e.wrp   = 1'b1;
                        end else begin
                            m_units++;
                        end
                    end else begin
                        m_frac++;
                    end
                end else begin
                    m_pcnt++;
                end
            end
            if (arm) begin
                m_armed = 1'b1;
                m_cmp   = int'(aunits);
            end else if (m_armed && e.unit && (m_units == m_cmp)) begin
                e.alm   = 1'b1;
                m_armed = 1'b0;
            end
        end
        e.units = UW'(m_units);
        e.frac  = 4'(m_frac);
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        obs_t o;
        #12;
        o = observe();
        vectors++;
        if (o !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL reset_state: got %p expected all zero", o);
        end
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_first_tick();
        obs_t e, o;
        for (int i = 0; i < CPT; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL first_tick[%0d]: got %p expected %p", i, o, e);
            end
        end
        vectors++;
        if (prec_tick !== 1'b1 || ts_frac !== 4'd1) begin
            miscompares++;
            $display("FAIL first_tick_cycle5: got prec_tick=%b ts_frac=%0d expected 1 and 1", prec_tick, ts_frac);
        end
    endtask

    task automatic test_unit_tick();
        obs_t e, o;
        int   unit_pulses = 0;
        for (int i = 0; i < 40 - CPT; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            if (o.unit === 1'b1) unit_pulses++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL unit_tick[%0d]: got %p expected %p", i, o, e);
            end
        end
        vectors++;
        if (unit_pulses != 1 || unit_tick !== 1'b1 || prec_tick !== 1'b1 || ts_units !== 4'd1 || ts_frac !== 4'd0) begin
            miscompares++;
            $display("FAIL unit_after_40: got pulses=%0d unit=%b prec=%b units=%0d frac=%0d expected 1 1 1 1 0",
                     unit_pulses, unit_tick, prec_tick, ts_units, ts_frac);
        end
    endtask

    task automatic test_enable_gap();
        obs_t e, o;
        logic pattern [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int   tick_at = -1;
        for (int i = 0; i < 8; i++) begin
            drive(pattern[i], 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            if (o.prec === 1'b1 && tick_at < 0) tick_at = i + 1;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL enable_gap[%0d]: got %p expected %p", i, o, e);
            end
        end
        vectors++;
        if (tick_at != 6) begin
            miscompares++;
            $display("FAIL enable_gap_delay: got tick on cycle %0d expected cycle 6", tick_at);
        end
    endtask

    task automatic test_wrap();
        obs_t e, o;
        int   wraps = 0;
        int   budget = 0;
        while (ts_units !== 4'(UMAX) && budget < 1000) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            if (o.wrp === 1'b1) wraps++;
            budget++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wrap_run[%0d]: got %p expected %p", budget, o, e);
            end
        end
        vectors++;
        if (budget >= 1000) begin
            miscompares++;
            $display("FAIL wrap_reach15: got ts_units=%0d after %0d cycles expected %0d", ts_units, budget, UMAX);
        end
        for (int i = 0; i < CPT * TPU; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            if (o.wrp === 1'b1) wraps++;
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL wrap_last[%0d]: got %p expected %p", i, o, e);
            end
        end
        vectors++;
        if (wraps != 1 || wrap !== 1'b1 || unit_tick !== 1'b1 || ts_units !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_pulse: got wraps=%0d wrap=%b unit=%b units=%0d expected 1 1 1 0",
                     wraps, wrap, unit_tick, ts_units);
        end
    endtask

    task automatic test_clear();
        obs_t e, o;
        for (int i = 0; i < CPT + 1 && m_pcnt != CPT - 1; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL clear_prep[%0d]: got %p expected %p", i, o, e);
            end
        end
        drive(1'b1, 1'b1, 1'b0, '0);
        e = sb.pop_front();
        o = observe();
        vectors++;
        if (o !== e || o !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL clear_over_enable: got %p expected all zero", o);
        end
        for (int i = 0; i < CPT; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL clear_resume[%0d]: got %p expected %p", i, o, e);
            end
        end
        vectors++;
        if (prec_tick !== 1'b1 || ts_frac !== 4'd1 || ts_units !== 4'd0) begin
            miscompares++;
            $display("FAIL clear_first_tick: got prec=%b frac=%0d units=%0d expected 1 1 0", prec_tick, ts_frac, ts_units);
        end
    endtask

    task automatic test_async_reset();
        obs_t e, o;
        for (int i = 0; i < 47; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL async_prep[%0d]: got %p expected %p", i, o, e);
            end
        end
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        o = observe();
        vectors++;
        if (o !== obs_t'(0)) begin
            miscompares++;
            $display("FAIL async_reset_immediate: got %p expected all zero", o);
        end
        model_reset();
        enable = 1'b0;
        clear  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < CPT; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL async_resume[%0d]: got %p expected %p", i, o, e);
            end
        end
        vectors++;
        if (prec_tick !== 1'b1 || ts_frac !== 4'd1 || ts_units !== 4'd0) begin
            miscompares++;
            $display("FAIL async_first_tick: got prec=%b frac=%0d units=%0d expected 1 1 0", prec_tick, ts_frac, ts_units);
        end
    endtask

`ifdef TS_ALARM_EN
    task automatic test_alarm();
        obs_t e, o;
        int   pulses = 0;
        int   units_at = -1;
        drive(1'b0, 1'b1, 1'b0, '0);
        e = sb.pop_front();
        drive(1'b1, 1'b0, 1'b1, 4'd3);
        e = sb.pop_front();
        o = observe();
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL alarm_arm: got %p expected %p", o, e);
        end
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0);
            e = sb.pop_front();
            o = observe();
            if (o.alm === 1'b1) begin
                pulses++;
                units_at = int'(o.units);
            end
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL alarm_run[%0d]: got %p expected %p", i, o, e);
            end
        end
        vectors++;
        if (pulses != 1 || units_at != 3) begin
            miscompares++;
            $display("FAIL alarm_pulse: got pulses=%0d at units=%0d expected 1 at 3", pulses, units_at);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_tick();
        test_unit_tick();
        test_enable_gap();
        test_wrap();
        test_clear();
        test_async_reset();
`ifdef TS_ALARM_EN
        test_alarm();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
